// File: rtl/mpu_commit_ctrl.sv
// Issue-number allocator and in-order commit tracker for the MPU dispatch path.
// Threads are allocated at the tail, committed per TPU, and retired from the head in issue order.
module mpu_commit_ctrl #(
    parameter int NUM_ENTRY      = 8,
    parameter int WIDTH_ENTRY    = 3,
    parameter int NUM_TPUS       = 1,
    parameter int WIDTH_THREADID = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            I_Req,
    input  logic [WIDTH_THREADID-1:0]       I_ThreadID,
    input  logic [NUM_TPUS-1:0]             I_En_TPU,
    output logic                            O_Ack,
    output logic [WIDTH_ENTRY-1:0]          O_IssueNo,
    input  logic [NUM_TPUS-1:0]             I_Commit,
    input  logic [NUM_TPUS*WIDTH_ENTRY-1:0] I_Commit_No,
    output logic                            O_Retire,
    output logic [WIDTH_THREADID-1:0]       O_Retire_ID,
    output logic [WIDTH_ENTRY-1:0]          O_Retire_No,
    input  logic                            I_Drain,
    output logic                            O_Drained,
    output logic                            O_Full,
    output logic                            O_Empty,
    output logic [WIDTH_ENTRY:0]            O_Count,
    output logic                            O_Err
);
    // state | meaning
    // RUN   | allocation allowed while table has space
    // DRAIN | allocation blocked; commits and retires continue until host releases
    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    localparam int CNT_W = WIDTH_ENTRY + 1;

    state_t                    state_q, state_d;
    logic [NUM_ENTRY-1:0]      valid_q, valid_d;
    logic [NUM_TPUS-1:0]       wait_q [NUM_ENTRY];
    logic [NUM_TPUS-1:0]       wait_d [NUM_ENTRY];
    logic [WIDTH_THREADID-1:0] tid_q  [NUM_ENTRY];
    logic [WIDTH_ENTRY-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      retire_d;
    logic                      commit_err;

    assign O_Full    = (count_q == CNT_W'(NUM_ENTRY));
    assign O_Empty   = (count_q == '0);
    assign O_Count   = count_q;
    assign O_IssueNo = tail_q;
    assign O_Ack     = I_Req & ~O_Full & (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        wait_d     = wait_q;
        commit_err = 1'b0;
        retire_d   = valid_q[head_q] && (wait_q[head_q] == '0);

        case (state_q)
            ST_RUN:   if (I_Drain)  state_d = ST_DRAIN;
            ST_DRAIN: if (!I_Drain) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        // Legality is judged on registered state, so a same-cycle allocation cannot be committed.
        for (int k = 0; k < NUM_TPUS; k++) begin
            if (I_Commit[k]) begin
                if (valid_q[I_Commit_No[k*WIDTH_ENTRY +: WIDTH_ENTRY]] &&
                    wait_q[I_Commit_No[k*WIDTH_ENTRY +: WIDTH_ENTRY]][k]) begin
                    wait_d[I_Commit_No[k*WIDTH_ENTRY +: WIDTH_ENTRY]][k] = 1'b0;
                end else begin
                    commit_err = 1'b1;
                end
            end
        end

        if (retire_d) begin
            valid_d[head_q] = 1'b0;
            wait_d[head_q]  = '0;
        end

        // Head and tail only coincide when full (no ack) or empty (no retire), so these never collide.
        if (O_Ack) begin
            valid_d[tail_q] = 1'b1;
            wait_d[tail_q]  = I_En_TPU;
        end

        count_d = count_q + CNT_W'(O_Ack) - CNT_W'(retire_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            valid_q     <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) wait_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            O_Retire    <= 1'b0;
            O_Retire_ID <= '0;
            O_Retire_No <= '0;
            O_Drained   <= 1'b0;
            O_Err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            O_Retire  <= retire_d;
            O_Drained <= (state_d == ST_DRAIN) && (count_d == '0);
            O_Err     <= O_Err | commit_err;
            if (O_Ack) tail_q <= tail_q + WIDTH_ENTRY'(1);
            if (retire_d) begin
                head_q      <= head_q + WIDTH_ENTRY'(1);
                O_Retire_ID <= tid_q[head_q];
                O_Retire_No <= head_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (O_Ack) tid_q[tail_q] <= I_ThreadID;
    end

endmodule
